// File: rtl/bdm_interface.sv
// bdm_interface: host byte parser, 16-entry {op,arg} FIFO and BDM bit engine on an open-drain bkgd line.
// Optional BOOT sync timeout is built in when BDM_SYNC_TIMEOUT_EN is defined.
module bdm_interface (
    input  logic       clk,
    input  logic       rst_in,
    input  logic       new_rx_data,
    input  logic [7:0] rx_data,
    output logic       new_tx_data,
    output logic [7:0] tx_data,
    input  logic       tx_block,
    inout  wire        bkgd,
    output logic       mcu_pwr
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD   = 4'd1;
    localparam logic [3:0] S_FETCH  = 4'd2;
    localparam logic [3:0] S_SEND   = 4'd3;
    localparam logic [3:0] S_DELAY  = 4'd4;
    localparam logic [3:0] S_WRITE  = 4'd5;
    localparam logic [3:0] S_READ   = 4'd6;
    localparam logic [3:0] S_B_OFF  = 4'd7;
    localparam logic [3:0] S_B_PWR  = 4'd8;
    localparam logic [3:0] S_B_REL  = 4'd9;
    localparam logic [3:0] S_B_SYNC = 4'd10;
    localparam logic [3:0] S_B_WAIT = 4'd11;
    localparam logic [3:0] S_B_MEAS = 4'd12;
    localparam logic [3:0] S_B_DONE = 4'd13;

    logic [3:0]  state;
    logic [3:0]  ret_state;
    logic [7:0]  tx_byte;
    logic [15:0] fifo_mem [16];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    logic [4:0]  count;
    logic [7:0]  load_left;
    logic        load_odd;
    logic [7:0]  op_hold;
    logic [7:0]  cur_arg;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [15:0] tick;
    logic [15:0] meas;
    logic [8:0]  bit_unit;
    logic        sync1;
    logic        sync2;
    logic        timed_out;
    logic        drive_low;
    logic        push;
    logic [15:0] unit;
    logic [15:0] u4;
    logic [15:0] u10;
    logic [15:0] u13;
    logic [15:0] u16;
    logic [15:0] head;

    assign unit = {7'd0, bit_unit};
    assign u4   = unit << 2;
    assign u10  = (unit << 3) + (unit << 1);
    assign u13  = (unit << 3) + (unit << 2) + unit;
    assign u16  = unit << 4;
    assign head = fifo_mem[rd_ptr];

    // Second byte of a pair completes an entry; a full FIFO silently drops it.
    assign push = (state == S_LOAD) && new_rx_data && load_odd && (count != 5'd16);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {op_hold, rx_data};
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bkgd;
            sync2 <= sync1;
        end
    end

    always_comb begin
        drive_low = 1'b0;
        case (state)
            S_WRITE:           drive_low = tick < (shreg[7] ? u4 : u13);
            S_READ:            drive_low = tick < u4;
            S_B_PWR, S_B_SYNC: drive_low = 1'b1;
            default:           ;
        endcase
    end

    assign bkgd        = drive_low ? 1'b0 : 1'bz;
    assign new_tx_data = (state == S_SEND) && !tx_block;
    assign tx_data     = tx_byte;

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state     <= S_IDLE;
            ret_state <= S_IDLE;
            tx_byte   <= 8'h00;
            wr_ptr    <= 4'd0;
            rd_ptr    <= 4'd0;
            count     <= 5'd0;
            load_left <= 8'd0;
            load_odd  <= 1'b0;
            op_hold   <= 8'h00;
            cur_arg   <= 8'h00;
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            tick      <= 16'd0;
            meas      <= 16'd0;
            bit_unit  <= 9'd1;
            timed_out <= 1'b0;
            mcu_pwr   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (new_rx_data) begin
                        if (rx_data == 8'h01) begin
                            state <= S_FETCH;
                        end else if (rx_data == 8'h04) begin
                            tx_byte   <= {3'd0, count};
                            ret_state <= S_IDLE;
                            state     <= S_SEND;
                        end else if (rx_data[7] && (rx_data[6:0] != 7'd0)) begin
                            load_left <= {rx_data[6:0], 1'b0};
                            load_odd  <= 1'b0;
                            state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (new_rx_data) begin
                        if (!load_odd) begin
                            op_hold <= rx_data;
                        end
                        if (push) begin
                            wr_ptr <= wr_ptr + 4'd1;
                            count  <= count + 5'd1;
                        end
                        load_odd  <= ~load_odd;
                        load_left <= load_left - 8'd1;
                        if (load_left == 8'd1) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_FETCH: begin
                    if (count == 5'd0) begin
                        state <= S_IDLE;
                    end else begin
                        rd_ptr  <= rd_ptr + 4'd1;
                        count   <= count - 5'd1;
                        cur_arg <= head[7:0];
                        shreg   <= head[7:0];
                        tick    <= 16'd0;
                        bit_cnt <= 3'd0;
                        case (head[15:8])
                            8'h01: state <= S_READ;
                            8'h02: state <= S_WRITE;
                            8'h03: begin
                                mcu_pwr   <= 1'b0;
                                timed_out <= 1'b0;
                                state     <= S_B_OFF;
                            end
                            8'h05: begin
                                tx_byte   <= head[7:0];
                                ret_state <= S_FETCH;
                                state     <= S_SEND;
                            end
                            8'h06:   state <= S_DELAY;
                            default: state <= S_FETCH;
                        endcase
                    end
                end
                S_SEND: begin
                    if (!tx_block) begin
                        state <= ret_state;
                    end
                end
                S_DELAY: begin
                    if (({1'b0, tick} + 17'd1) >= {5'd0, cur_arg, 4'd0}) begin
                        state <= S_FETCH;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_WRITE: begin
                    if (tick == u16 - 16'd1) begin
                        tick    <= 16'd0;
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_FETCH;
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_READ: begin
                    if (tick == u10) begin
                        shreg <= {shreg[6:0], sync2};
                        tick  <= tick + 16'd1;
                    end else if (tick == u16 - 16'd1) begin
                        tick    <= 16'd0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            tx_byte   <= shreg;
                            ret_state <= S_FETCH;
                            state     <= S_SEND;
                        end
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_B_OFF: begin
                    if (tick == 16'd3999) begin
                        tick    <= 16'd0;
                        mcu_pwr <= 1'b1;
                        state   <= S_B_PWR;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_B_PWR: begin
                    if (tick == 16'd3999) begin
                        tick  <= 16'd0;
                        state <= S_B_REL;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_B_REL: begin
                    if (tick == 16'd15) begin
                        tick  <= 16'd0;
                        state <= S_B_SYNC;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                S_B_SYNC: begin
                    if (tick == 16'd511) begin
                        tick  <= 16'd0;
                        state <= S_B_WAIT;
                    end else begin
                        tick <= tick + 16'd1;
                    end
                end
                // Our own sync pulse is still in the synchronizer for two cycles; skip it.
                S_B_WAIT: begin
                    if ((tick >= 16'd2) && !sync2) begin
                        meas  <= 16'd1;
                        state <= S_B_MEAS;
                    end
`ifdef BDM_SYNC_TIMEOUT_EN
                    else if (tick == 16'hFFFF) begin
                        timed_out <= 1'b1;
                        meas      <= 16'd0;
                        tx_byte   <= 8'h00;
                        ret_state <= S_B_DONE;
                        state     <= S_SEND;
                    end
`endif
                    else if (tick != 16'hFFFF) begin
                        tick <= tick + 16'd1;
                    end
                end
                S_B_MEAS: begin
                    if (!sync2) begin
                        if (meas != 16'hFFFF) begin
                            meas <= meas + 16'd1;
                        end
                    end else begin
                        tx_byte   <= meas[15:8];
                        ret_state <= S_B_DONE;
                        state     <= S_SEND;
                    end
                end
                S_B_DONE: begin
                    tx_byte   <= meas[7:0];
                    ret_state <= S_FETCH;
                    state     <= S_SEND;
                    if (!timed_out) begin
                        bit_unit <= (meas[15:7] == 9'd0) ? 9'd1 : meas[15:7];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bdm_interface.sv
// Bench for bdm_interface: vector table, reset/backpressure/BOOT sequences and a randomized
// host session checked against a queue-based command model.
module tb_bdm_interface;

    logic       clk = 1'b0;
    logic       rst_in = 1'b0;
    logic       new_rx_data = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_block = 1'b0;
    logic       tgt_low = 1'b0;
    logic       new_tx_data;
    logic [7:0] tx_data;
    logic       mcu_pwr;
    wire        bkgd;

    assign bkgd = tgt_low ? 1'b0 : 1'bz;
    pullup (bkgd);

    always #5 clk = ~clk;

    bdm_interface dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .new_rx_data(new_rx_data),
        .rx_data    (rx_data),
        .new_tx_data(new_tx_data),
        .tx_data    (tx_data),
        .tx_block   (tx_block),
        .bkgd       (bkgd),
        .mcu_pwr    (mcu_pwr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          got_pw[$];
    int          exp_pw[$];
    logic [15:0] mdl_q[$];
    logic [15:0] load_q[$];
    int          mdl_bu = 1;
    int          run_len = 0;
    int          pwr_rises = 0;
    logic        pwr_prev = 1'b0;

    typedef struct packed {
        logic [2:0]  n_in;
        logic [47:0] in_b;
        logic [2:0]  n_exp;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[10];

    // Monitor: collects host strobes, host-driven low pulse widths and power-on edges.
    always @(negedge clk) begin
        if (new_tx_data) begin
            got_q.push_back(tx_data);
            n_tests++;
            if (tx_block) begin
                n_fail++;
                $display("FAIL strobe_while_blocked: got strobe with byte %02h, required none", tx_data);
            end
        end
        if (bkgd === 1'b0 && !tgt_low) begin
            run_len++;
        end else if (run_len > 0) begin
            got_pw.push_back(run_len);
            run_len = 0;
        end
        if (mcu_pwr && !pwr_prev) pwr_rises++;
        pwr_prev = mcu_pwr;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        new_rx_data = 1'b1;
        rx_data     = b;
        step(1);
        new_rx_data = 1'b0;
        step(gap);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            step(1);
            c++;
        end
    endtask

    task automatic check_queues(input string tag);
        check({tag, " tx_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s tx_byte%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
        check({tag, " pulse_count"}, got_pw.size(), exp_pw.size());
        for (int i = 0; i < got_pw.size() && i < exp_pw.size(); i++)
            check($sformatf("%s pulse%0d", tag, i), got_pw[i], exp_pw[i]);
        got_q.delete();
        exp_q.delete();
        got_pw.delete();
        exp_pw.delete();
    endtask

    // Host LOAD of load_q; the model keeps at most 16 entries.
    task automatic do_load();
        send_byte(8'h80 | 8'(load_q.size()), $urandom_range(0, 1));
        foreach (load_q[k]) begin
            send_byte(load_q[k][15:8], $urandom_range(0, 1));
            send_byte(load_q[k][7:0], $urandom_range(0, 1));
            if (mdl_q.size() < 16) mdl_q.push_back(load_q[k]);
        end
        step(2);
    endtask

    task automatic do_depth();
        send_byte(8'h04, 0);
        exp_q.push_back(8'(mdl_q.size()));
        step(4);
    endtask

    // RUN with an idle-high target: reads return 0xFF; writes show 4 or 13 unit low pulses.
    task automatic do_run();
        int bound = 20;
        logic [15:0] e;
        while (mdl_q.size() > 0) begin
            e = mdl_q.pop_front();
            case (e[15:8])
                8'h01: begin
                    exp_q.push_back(8'hFF);
                    for (int b = 0; b < 8; b++) exp_pw.push_back(4 * mdl_bu);
                    bound += 128 * mdl_bu + 4;
                end
                8'h02: begin
                    for (int b = 7; b >= 0; b--) exp_pw.push_back(e[b] ? 4 * mdl_bu : 13 * mdl_bu);
                    bound += 128 * mdl_bu + 4;
                end
                8'h05: begin
                    exp_q.push_back(e[7:0]);
                    bound += 4;
                end
                8'h06:   bound += int'(e[7:0]) * 16 + 4;
                default: bound += 2;
            endcase
        end
        send_byte(8'h01, 0);
        step(bound);
    endtask

    initial begin
        logic [7:0] b;
        int n;
        int sel;

        vecs[0] = '{3'd1, 48'h04_00_00_00_00_00, 3'd1, 32'h00_00_00_00};
        vecs[1] = '{3'd6, 48'h82_05_7B_05_D5_04, 3'd1, 32'h02_00_00_00};
        vecs[2] = '{3'd1, 48'h01_00_00_00_00_00, 3'd2, 32'h7B_D5_00_00};
        vecs[3] = '{3'd1, 48'h04_00_00_00_00_00, 3'd1, 32'h00_00_00_00};
        vecs[4] = '{3'd2, 48'h80_04_00_00_00_00, 3'd1, 32'h00_00_00_00};
        vecs[5] = '{3'd3, 48'h55_02_04_00_00_00, 3'd1, 32'h00_00_00_00};
        vecs[6] = '{3'd4, 48'h81_07_99_04_00_00, 3'd1, 32'h01_00_00_00};
        vecs[7] = '{3'd1, 48'h01_00_00_00_00_00, 3'd0, 32'h00_00_00_00};
        vecs[8] = '{3'd4, 48'h81_05_A5_01_00_00, 3'd1, 32'hA5_00_00_00};
        vecs[9] = '{3'd1, 48'h04_00_00_00_00_00, 3'd1, 32'h00_00_00_00};

        // Reset values
        step(3);
        @(negedge clk);
        check("reset new_tx_data", int'(new_tx_data), 0);
        check("reset tx_data", int'(tx_data), 0);
        check("reset mcu_pwr", int'(mcu_pwr), 0);
        check("reset bkgd", int'(bkgd), 1);
        step(1);
        rst_in = 1'b1;
        step(2);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < int'(vecs[i].n_in); j++)
                send_byte(vecs[i].in_b[47 - 8 * j -: 8], 0);
            wait_tx(int'(vecs[i].n_exp), 300);
            step(10);
            for (int j = 0; j < int'(vecs[i].n_exp); j++)
                exp_q.push_back(vecs[i].exp_b[31 - 8 * j -: 8]);
            check_queues($sformatf("vec%0d", i));
        end

        // Reset in the middle of a LOAD: FIFO and byte counter are discarded
        load_q = '{16'h0566};
        do_load();
        do_depth();
        send_byte(8'h82, 0);
        send_byte(8'h05, 0);
        send_byte(8'h77, 0);
        rst_in = 1'b0;
        #2;
        check("async_reset tx_data", int'(tx_data), 0);
        mdl_q.delete();
        step(2);
        rst_in = 1'b1;
        step(1);
        send_byte(8'h22, 0);
        do_depth();
        check_queues("load_reset");

        // Backpressure while the second echo is pending
        load_q = '{16'h053C, 16'h0601, 16'h05C3};
        do_load();
        send_byte(8'h01, 0);
        mdl_q.delete();
        wait_tx(1, 100);
        tx_block = 1'b1;
        step(20);
        check("blocked strobe_count", got_q.size(), 1);
        tx_block = 1'b0;
        @(negedge clk);
        check("release strobe", int'(new_tx_data), 1);
        check("release byte", int'(tx_data), 8'hC3);
        step(1);
        @(negedge clk);
        check("release strobe_width", int'(new_tx_data), 0);
        exp_q = '{8'h3C, 8'hC3};
        step(2);
        check_queues("tx_block");

        // Overflow: 17 echoes loaded, 16 kept
        load_q.delete();
        for (int i = 0; i < 17; i++) load_q.push_back({8'h05, 8'(i + 8'h30)});
        do_load();
        do_depth();
        do_run();
        do_depth();
        check_queues("overflow");

        // Randomized host session
        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom_range(2, 127));
            if (b == 8'h04) b = 8'h03;
            send_byte(b, 0);
            load_q.delete();
            n = $urandom_range(0, 5);
            for (int k = 0; k < n; k++) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    1:       load_q.push_back(16'h0100);
                    2:       load_q.push_back({8'h02, 8'($urandom_range(0, 255))});
                    3:       load_q.push_back({8'h06, 8'($urandom_range(0, 4))});
                    4:       load_q.push_back({8'($urandom_range(7, 127)), 8'($urandom_range(0, 255))});
                    default: load_q.push_back({8'h05, 8'($urandom_range(0, 255))});
                endcase
            end
            do_load();
            do_depth();
            if (r == 5 || $urandom_range(0, 1) == 1) do_run();
            check_queues($sformatf("random%0d", r));
        end

        // BOOT with a target answering the sync request with a 1457-cycle low
        pwr_rises = 0;
        send_byte(8'h81, 0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        step(2000);
        @(negedge clk);
        check("boot power_off", int'(mcu_pwr), 0);
        check("boot bkgd_released", int'(bkgd), 1);
        step(4000);
        @(negedge clk);
        check("boot power_on", int'(mcu_pwr), 1);
        check("boot bkgd_low", int'(bkgd), 0);
        step(4000);
        tgt_low = 1'b1;
        step(1457);
        tgt_low = 1'b0;
        wait_tx(2, 300);
        step(5);
        check("boot power_rises", pwr_rises, 1);
        exp_q  = '{8'h05, 8'hB1};
        exp_pw = '{4000, 512};
        check_queues("boot");
        mdl_bu = (1457 / 128 < 1) ? 1 : 1457 / 128;

        // Reads at the measured bit unit with an idle-high target
        load_q = '{16'h0100, 16'h061E, 16'h0100, 16'h061E};
        do_load();
        do_run();
        do_depth();
        check_queues("reads");

`ifdef BDM_SYNC_TIMEOUT_EN
        // BOOT with no target response times out and returns to IDLE
        pwr_rises = 0;
        send_byte(8'h81, 0);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        wait_tx(2, 75000);
        step(5);
        do_depth();
        check("timeout power_rises", pwr_rises, 1);
        exp_q  = '{8'h00, 8'h00, 8'h00};
        exp_pw = '{4000, 512};
        check_queues("timeout");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bdm_interface.md
BDM_INTERFACE -- requirements
Module: bdm_interface

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_in  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: new_rx_data  in  1  host byte valid, one byte per cycle while high.
REQ-004 SHALL have ports: rx_data  in  8  host byte.
REQ-005 SHALL have ports: new_tx_data  out  1  one-cycle strobe, tx_data valid.
REQ-006 SHALL have ports: tx_data  out  8  byte to host.
REQ-007 SHALL have ports: tx_block  in  1  host backpressure; no strobe while high.
REQ-008 SHALL have ports: bkgd  inout  1  open-drain BDM line; drives 0 or high-Z only, never 1.
REQ-009 SHALL have ports: mcu_pwr  out  1  target power enable, 1 = on.

Function
REQ-010 SHALL parse host bytes while IDLE:
- 0x01 = RUN.
- 0x04 = DEPTH: send one byte holding the FIFO entry count.
- 0x80|N = LOAD: the next 2N bytes are N {op,arg} pairs pushed to the FIFO; N=0 is a no-op.
- Any other byte is ignored.
REQ-011 FIFO SHALL hold 16 {op,arg} entries; pushes while full are dropped; the count saturates at 16.
REQ-012 While RUNNING, host bytes SHALL be ignored; RUN pops and executes entries in order and returns to IDLE when the FIFO is empty.
REQ-013 Ops:
- 0x01 READ: clock 8 bits from the target, MSB first, and send the byte.
- 0x02 WRITE: send arg to the target, MSB first.
- 0x03 BOOT: power-cycle the target, then perform a sync measurement.
- 0x05 ECHO: send arg.
- 0x06 DELAY: wait arg*16 cycles.
- Any other op: discarded in one cycle.
REQ-014 BOOT sequence:
- mcu_pwr=0 for 4000 cycles.
- mcu_pwr=1 with bkgd driven low for 4000 cycles.
- Release bkgd for 16 cycles.
- Drive bkgd low for 512 cycles (sync request), then release.
- Wait for bkgd low, then count cycles until bkgd high (16-bit, saturating).
- Send count high byte, then low byte.
- Store bit_unit = max(1, count>>7).
REQ-015 bkgd SHALL be sampled through a 2-flop synchronizer; the same latency applies to both edges, so the measured count is exact.
REQ-016 WRITE bit timing, 16 bit_unit per bit:
- Bit 1: drive low for 4 units, then release.
- Bit 0: drive low for 13 units, then release.
REQ-017 READ bit timing: drive low for 4 units, release, sample at 10 units, bit period 16 units.
REQ-018 Every sent byte SHALL assert new_tx_data for exactly one cycle when tx_block=0; while tx_block=1 the engine SHALL stall holding the pending byte, then send it on the first cycle tx_block=0.
REQ-019 A LOAD interrupted by reset SHALL be discarded.

Reset
REQ-020 On rst_in=0 the block SHALL reset asynchronously to:
- new_tx_data=0, tx_data=0x00, mcu_pwr=0.
- bkgd released.
- FIFO empty, bit_unit=1, state IDLE, LOAD byte counter cleared.

Configuration
REQ-021 The macro BDM_SYNC_TIMEOUT_EN SHALL select the BOOT timeout behaviour:
- Defined: if bkgd is not seen low within 65535 cycles after the sync request, BOOT sends 0x00,0x00, keeps bit_unit, and continues.
- Undefined: BOOT waits indefinitely.

Verification
REQ-022 Reset, then send 0x82,0x05,0x7B,0x05,0xD5, then 0x04 -> tx byte 0x02.
REQ-023 Then send 0x01 -> tx 0x7B then 0xD5, each a single-cycle strobe; FIFO count 0 afterwards.
REQ-024 Hold tx_block=1 for 20 cycles when the second echo is pending -> no strobe during the block, strobe on the first cycle after release, byte unchanged.
REQ-025 Send 0x81,0x03,0x00,0x01 with the target pulling bkgd low for 1457 cycles starting about 10000 cycles after the command -> mcu_pwr pulses 0 then 1, tx 0x05 then 0xB1, bit_unit=11.
REQ-026 Then send 0x84,0x01,0x00,0x06,0x1E,0x01,0x00,0x06,0x1E,0x01 with bkgd idle-high -> tx 0xFF, then 0xFF, each read's host low pulses 44 cycles wide.
REQ-027 With BDM_SYNC_TIMEOUT_EN defined and no target response, BOOT -> tx 0x00,0x00 and returns to IDLE.
